// File: rtl/mbist_pkg.sv
// Shared types and March element tables for the MBIST/MBISR controller.
// Each element lists its address direction, how many ops it runs per address, and what those ops do.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_MARCH_C = 1'b0;
  localparam logic MODE_MATS    = 1'b1;

  typedef struct packed {
    logic down;     // 1 = descending address order
    logic two_ops;  // 0 = op0 only, 1 = op0 then op1
    logic op0_rd;
    logic op0_val;  // background bit for op0 (read expect / write data)
    logic op1_rd;
    logic op1_val;
  } elem_t;

  localparam int MARCH_C_LEN = 6;
  localparam int MATS_LEN    = 3;

  // Elements written as "either order" run ascending.
  localparam elem_t MARCH_C_TBL [MARCH_C_LEN] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  localparam elem_t MATS_TBL [MATS_LEN] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}
  };

  function automatic elem_t get_elem(input logic mode, input logic [2:0] idx);
    elem_t e;
    e = '0;
    if (mode == MODE_MATS) begin
      if (idx < 3'(MATS_LEN)) e = MATS_TBL[idx[1:0]];
    end else if (idx < 3'(MARCH_C_LEN)) begin
      e = MARCH_C_TBL[idx];
    end
    return e;
  endfunction

  function automatic logic [2:0] last_elem(input logic mode);
    return (mode == MODE_MATS) ? 3'(MATS_LEN - 1) : 3'(MARCH_C_LEN - 1);
  endfunction

endpackage

// File: rtl/mbisr_spare_table.sv
// Spare-row remap table: logs failing addresses into the lowest free entry and flags overflow.
// It also provides a combinational lookup of functional addresses against the valid entries.
module mbisr_spare_table #(
  parameter int NUM_SPARES = 2,
  parameter int ADDR_W     = 4,
  parameter int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
  parameter int USED_W     = $clog2(NUM_SPARES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              log_i,
  input  logic [ADDR_W-1:0] log_addr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_hit_o,
  output logic [IDX_W-1:0]  lookup_idx_o,
  output logic              overflow_o,
  output logic [USED_W-1:0] used_o
);

  logic [NUM_SPARES-1:0] valid_q;
  logic [ADDR_W-1:0]     addr_q [NUM_SPARES];
  logic [USED_W-1:0]     used_q;
  logic                  ovf_q;
  logic                  log_hit;
  logic                  any_free;
  logic [IDX_W-1:0]      free_idx;

  // Scanning high to low leaves the lowest matching / free index as the result.
  always_comb begin
    log_hit      = 1'b0;
    any_free     = 1'b0;
    free_idx     = '0;
    lookup_hit_o = 1'b0;
    lookup_idx_o = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == log_addr_i)) log_hit = 1'b1;
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (valid_q[i] && (addr_q[i] == lookup_addr_i)) begin
        lookup_hit_o = 1'b1;
        lookup_idx_o = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= '0;
      used_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (log_i && !log_hit) begin
      if (any_free) begin
        valid_q[free_idx] <= 1'b1;
        addr_q[free_idx]  <= log_addr_i;
        used_q            <= used_q + USED_W'(1);
      end else begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign overflow_o = ovf_q;
  assign used_o     = used_q;

endmodule

// File: rtl/mbist_march_repair.sv
// MBIST controller: runs March C- or MATS+ over an external single-port SRAM at one op per cycle.
// Each read is compared one cycle later, and failing addresses are logged into the spare remap table.
module mbist_march_repair
  import mbist_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int NUM_SPARES = 2,
  parameter int CNT_W      = 8,
  parameter int USED_W     = $clog2(NUM_SPARES + 1),
  parameter int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              repairable,
  output logic              repair_overflow,
  output logic [CNT_W-1:0]  fail_count,
  output logic [USED_W-1:0] spare_used,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [IDX_W-1:0]  lookup_idx,
  output state_e            dbg_state
);

  state_e            state_q;
  logic              mode_q;
  logic [2:0]        elem_q;
  logic              opi_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              cmp_valid_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              fail_q;
  logic [CNT_W-1:0]  fail_cnt_q;

  logic              start_go;
  logic              mismatch;
  logic              mode_d;
  logic [2:0]        elem_d;
  logic [ADDR_W-1:0] addr_d;
  logic              opi_d;
  logic              op_rd_d;
  logic              op_val_d;
  logic              last_addr;
  logic              last_op;
  logic              new_elem;
  elem_t             cur_e;
  elem_t             nxt_e;

  assign start_go = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch = cmp_valid_q && (mem_rdata != cmp_exp_q);

  // Next op cursor: second op at the same address, then address step, then next element.
  always_comb begin
    mode_d    = (state_q == RUN) ? mode_q : mode;
    cur_e     = get_elem(mode_q, elem_q);
    last_addr = cur_e.down ? (mem_addr_q == '0) : (mem_addr_q == '1);
    elem_d    = elem_q;
    addr_d    = mem_addr_q;
    opi_d     = 1'b0;
    last_op   = 1'b0;
    new_elem  = 1'b0;
    if (state_q != RUN) begin
      elem_d   = '0;
      new_elem = 1'b1;
    end else if (cur_e.two_ops && !opi_q) begin
      opi_d = 1'b1;
    end else if (!last_addr) begin
      addr_d = cur_e.down ? (mem_addr_q - ADDR_W'(1)) : (mem_addr_q + ADDR_W'(1));
    end else if (elem_q == last_elem(mode_q)) begin
      last_op = 1'b1;
    end else begin
      elem_d   = elem_q + 3'd1;
      new_elem = 1'b1;
    end
    nxt_e = get_elem(mode_d, elem_d);
    if (new_elem) addr_d = nxt_e.down ? '1 : '0;
    op_rd_d  = opi_d ? nxt_e.op1_rd  : nxt_e.op0_rd;
    op_val_d = opi_d ? nxt_e.op1_val : nxt_e.op0_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      elem_q      <= '0;
      opi_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      // Read data arrives the cycle after the strobe; mem_wdata_q holds the expected background.
      cmp_valid_q <= mem_re_q;
      cmp_exp_q   <= mem_wdata_q;
      cmp_addr_q  <= mem_addr_q;
      if (mismatch) begin
        fail_q <= 1'b1;
        if (fail_cnt_q != {CNT_W{1'b1}}) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
      end
      if (start_go || ((state_q == RUN) && !last_op)) begin
        elem_q      <= elem_d;
        opi_q       <= opi_d;
        mem_addr_q  <= addr_d;
        mem_re_q    <= op_rd_d;
        mem_we_q    <= !op_rd_d;
        mem_wdata_q <= {DATA_W{op_val_d}};
      end else begin
        mem_re_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
      if (start_go) begin
        state_q    <= RUN;
        mode_q     <= mode;
        fail_q     <= 1'b0;
        fail_cnt_q <= '0;
      end else if ((state_q == RUN) && last_op) begin
        state_q <= DRAIN;
      end else if (state_q == DRAIN) begin
        state_q <= DONE;
      end
    end
  end

  mbisr_spare_table #(
    .NUM_SPARES(NUM_SPARES),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W),
    .USED_W    (USED_W)
  ) u_spares (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_go),
    .log_i        (mismatch),
    .log_addr_i   (cmp_addr_q),
    .lookup_addr_i(lookup_addr),
    .lookup_hit_o (lookup_hit),
    .lookup_idx_o (lookup_idx),
    .overflow_o   (repair_overflow),
    .used_o       (spare_used)
  );

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign fail       = fail_q;
  assign fail_count = fail_cnt_q;
  assign repairable = done && fail_q && !repair_overflow;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mbist_march_repair.sv
// Bench for mbist_march_repair: SRAM model with stuck-at faults, string-driven March reference model,
// op-trace scoreboard checked by a separate monitor, and end-of-run result/lookup checks.
module tb_mbist_march_repair;
  import mbist_pkg::*;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int NUM_SPARES = 2;
  localparam int CNT_W      = 6;
  localparam int N          = 1 << ADDR_W;
  localparam int USED_W     = $clog2(NUM_SPARES + 1);
  localparam int IDX_W      = 1;
  localparam int OP_W       = 2 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst, start, mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, done, fail, repairable, repair_overflow;
  logic [CNT_W-1:0]  fail_count;
  logic [USED_W-1:0] spare_used;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [IDX_W-1:0]  lookup_idx;
  state_e            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OP_W-1:0]   exp_q[$];
  logic [OP_W-1:0]   mon_got, mon_exp;
  logic [DATA_W-1:0] sram [N];
  logic [DATA_W-1:0] sa1  [N];
  logic [DATA_W-1:0] sa0  [N];
  int                exp_k, exp_cnt;
  bit                exp_ovf;
  int                spare_q[$];

  always #5 clk = ~clk;

  mbist_march_repair #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SPARES(NUM_SPARES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .repairable(repairable), .repair_overflow(repair_overflow),
    .fail_count(fail_count), .spare_used(spare_used),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
    .dbg_state(dbg_state)
  );

  // Synchronous SRAM with stuck-at bits applied on the read path.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (sram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory strobe must match the next op in the expected trace.
  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      mon_got = {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : {DATA_W{1'b0}}};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL op_unexpected: got %0h expected no op", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("op_trace", mon_got, mon_exp);
      end
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  task automatic add_fault(input int a, input int b, input bit v);
    if (v) begin
      sa1[a][b] = 1'b1;
      sa0[a][b] = 1'b0;
    end else begin
      sa0[a][b] = 1'b1;
      sa1[a][b] = 1'b0;
    end
  endtask

  // Reference model: walks the algorithm text ("^"/"v" direction, then r/w + value pairs).
  task automatic model_run(input logic m);
    string             alg[$];
    string             s;
    logic [DATA_W-1:0] mm [N];
    logic [DATA_W-1:0] bg, rd;
    int                nops, a;
    bit                down, found;
    exp_q.delete();
    spare_q.delete();
    exp_k   = 0;
    exp_cnt = 0;
    exp_ovf = 0;
    if (m) begin
      alg.push_back("^w0"); alg.push_back("^r0w1"); alg.push_back("vr1w0");
    end else begin
      alg.push_back("^w0"); alg.push_back("^r0w1"); alg.push_back("^r1w0");
      alg.push_back("vr0w1"); alg.push_back("vr1w0"); alg.push_back("^r0");
    end
    for (int i = 0; i < N; i++) mm[i] = DATA_W'($urandom);
    foreach (alg[e]) begin
      s    = alg[e];
      down = (s[0] == "v");
      nops = (s.len() - 1) / 2;
      for (int k = 0; k < N; k++) begin
        a = down ? (N - 1 - k) : k;
        for (int j = 0; j < nops; j++) begin
          bg = (s[2 + 2 * j] == "1") ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
          exp_k++;
          if (s[1 + 2 * j] == "w") begin
            mm[a] = bg;
            exp_q.push_back({1'b1, 1'b0, ADDR_W'(a), bg});
          end else begin
            exp_q.push_back({1'b0, 1'b1, ADDR_W'(a), {DATA_W{1'b0}}});
            rd = (mm[a] | sa1[a]) & ~sa0[a];
            if (rd != bg) begin
              if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
              found = 0;
              foreach (spare_q[q]) if (spare_q[q] == a) found = 1;
              if (!found) begin
                if (spare_q.size() < NUM_SPARES) spare_q.push_back(a);
                else exp_ovf = 1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic run_test(input string tag, input logic m, input bit hold);
    int c;
    bit hit;
    int idx;
    for (int i = 0; i < N; i++) sram[i] = DATA_W'($urandom);
    model_run(m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    c = 1;
    while (c <= exp_k + 20) begin
      @(negedge clk);
      mode = ~m;
      if (!hold || c >= exp_k) start = 1'b0;
      if (c == 1) begin
        check({tag, "_c1_busy"}, busy, 1);
        check({tag, "_c1_done"}, done, 0);
        check({tag, "_c1_fail"}, fail, 0);
        check({tag, "_c1_cnt"}, fail_count, 0);
        check({tag, "_c1_used"}, spare_used, 0);
        check({tag, "_c1_ovf"}, repair_overflow, 0);
      end
      if (done) break;
      @(posedge clk);
      c++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, c, exp_k + 2);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, DONE);
    check({tag, "_ops_left"}, exp_q.size(), 0);
    check({tag, "_fail"}, fail, (exp_cnt > 0));
    check({tag, "_fail_count"}, fail_count, exp_cnt);
    check({tag, "_spare_used"}, spare_used, spare_q.size());
    check({tag, "_overflow"}, repair_overflow, exp_ovf);
    check({tag, "_repairable"}, repairable, (exp_cnt > 0) && !exp_ovf);
    for (int a = 0; a < N; a++) begin
      hit = 0;
      idx = 0;
      foreach (spare_q[q]) if (spare_q[q] == a) begin hit = 1; idx = q; end
      lookup_addr = ADDR_W'(a);
      #1;
      check({tag, "_lookup_hit"}, lookup_hit, hit);
      check({tag, "_lookup_idx"}, lookup_idx, idx);
    end
  endtask

  task automatic reset_mid_run();
    int c;
    clear_faults();
    add_fault(2, 0, 1);
    model_run(1'b0);
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(posedge clk);
    c = 1;
    @(negedge clk);
    start = 1'b0;
    while (c < 50) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (c == 49) check("rst_pre_fail", fail, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_fail", fail, 0);
    check("rst_used", spare_used, 0);
    check("rst_state", dbg_state, IDLE);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_idle_state", dbg_state, IDLE);
    check("rst_idle_done", done, 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    mode        = 1'b0;
    lookup_addr = '0;
    clear_faults();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fail", fail, 0);
    check("reset_cnt", fail_count, 0);
    check("reset_used", spare_used, 0);
    check("reset_ovf", repair_overflow, 0);
    check("reset_we", mem_we, 0);
    check("reset_re", mem_re, 0);
    check("reset_hit", lookup_hit, 0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b0;

    run_test("mc_clean", 1'b0, 1'b0);
    check("mc_clean_k", exp_k, 160);

    add_fault(5, 0, 1);
    run_test("mc_sa1_a5", 1'b0, 1'b0);
    check("mc_sa1_a5_cnt3", fail_count, 3);

    clear_faults();
    add_fault(2, 3, 1);
    add_fault(9, 5, 1);
    add_fault(14, 1, 1);
    run_test("mc_ovf", 1'b0, 1'b1);

    clear_faults();
    run_test("mats_clean", 1'b1, 1'b0);
    check("mats_clean_k", exp_k, 80);

    for (int r = 0; r < 6; r++) begin
      int nf;
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int f = 0; f < nf; f++)
        add_fault($urandom_range(0, N - 1), $urandom_range(0, DATA_W - 1), 1'($urandom_range(0, 1)));
      run_test("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    clear_faults();
    for (int a = 0; a < N; a++) begin
      add_fault(a, 0, 0);
      add_fault(a, 1, 1);
    end
    run_test("mc_saturate", 1'b0, 1'b0);

    reset_mid_run();

    clear_faults();
    add_fault(7, 4, 0);
    run_test("mats_after_rst", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
